// File: rtl/fetch_unit.sv
// fetch_unit: PC holder issuing single-outstanding imem fetches into a small
// registered instruction FIFO, with redirect flush and stale-response dropping.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int PW = $clog2(BUF_DEPTH);
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            out_q, out_d, drop_q, drop_d, run_q;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] data_q [BUF_DEPTH];
  logic [XLEN-1:0] data_d [BUF_DEPTH];
  logic [XLEN-1:0] ipc_q  [BUF_DEPTH];
  logic [XLEN-1:0] ipc_d  [BUF_DEPTH];
  logic            accept, push, pop;
  // Requests are held off during a redirect so drop only ever covers an older fetch.
  assign imem_req_valid = run_q & ~out_q & (cnt_q < (PW+1)'(BUF_DEPTH)) & ~redirect_valid;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = imem_rsp_valid & out_q & ~drop_q & ~redirect_valid;
  assign pop            = instr_valid & instr_ready & ~redirect_valid;
  assign imem_addr      = pc_q;
  assign instr_valid    = cnt_q != '0;
  assign instr          = data_q[rd_q];
  assign instr_pc       = ipc_q[rd_q];
  assign op             = instr[6:0];
  always_comb begin
    pc_d     = redirect_valid ? (redirect_pc & ~XLEN'(3)) : accept ? pc_q + XLEN'(4) : pc_q;
    req_pc_d = accept ? pc_q : req_pc_q;
    out_d    = accept | (out_q & ~imem_rsp_valid);
    drop_d   = (redirect_valid | drop_q) & out_q & ~imem_rsp_valid;
    cnt_d    = redirect_valid ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_d     = redirect_valid ? '0 : wr_q + PW'(push);
    rd_d     = redirect_valid ? '0 : rd_q + PW'(pop);
    data_d   = data_q;
    ipc_d    = ipc_q;
    if (push) begin
      data_d[wr_q] = imem_rdata;
      ipc_d[wr_q]  = req_pc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      data_q   <= '{default: '0};
      ipc_q    <= '{default: '0};
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against an in-order memory model and a
// program-order scoreboard of expected {pc, word} pairs.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct { logic [31:0] a; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_addr, imem_rdata = 0, instr, instr_pc, redirect_pc = 0;
  logic instr_valid, instr_ready = 0, redirect_valid = 0;
  logic [6:0] op;
  int total = 0, bad = 0, pops = 0, cyc = 0;
  bit done = 0;
  mreq_t mem_q[$];
  exp_t  exp_q[$];
  logic [31:0] gen_pc = RESET_PC;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .op(op), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0)   return 32'h0000_2003;
    if (a == 32'h100) return 32'h0000_006F;
    return (a * 32'h9E37_79B1) ^ (a >> 3) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // Stimulus and memory model: inputs change at negedge, handshakes are resolved
  // at negedge+1 exactly as the coming posedge will see them.
  initial begin
    int rst_phase = 0;
    logic [31:0] t;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc = c;
      imem_rsp_valid = 0;
      redirect_valid = 0;
      if (rst_phase == 0 && (((c == 1000 || c == 2000) && mem_q.size() != 0) || (c > 400 && $urandom_range(299, 0) == 0)))
        rst_phase = 1;
      if (rst_phase == 1) begin
        rst_n = 0;
        exp_q.delete();
        gen_pc = RESET_PC;
        rst_phase = 2;
      end else if (rst_phase == 2) begin
        rst_phase = 3;
      end else if (rst_phase == 3) begin
        rst_n = 1;
        if (mem_q.size() != 0) begin
          imem_rsp_valid = 1;
          imem_rdata = mem_word(mem_q.pop_front().a);
        end
        rst_phase = 0;
      end else begin
        if (mem_q.size() != 0 && mem_q[0].due <= c) begin
          imem_rsp_valid = 1;
          imem_rdata = mem_word(mem_q.pop_front().a);
        end
        if (c < 200 || (c >= 300 && c < 316)) begin
          imem_req_ready = 1;
          instr_ready = c < 300;
        end else begin
          imem_req_ready = $urandom_range(99, 0) < 70;
          instr_ready = $urandom_range(99, 0) < 70;
          if ($urandom_range(99, 0) < 4) begin
            case ($urandom_range(3, 0))
              0: t = 32'h100;
              1: t = 32'h103;
              2: t = 32'hFFFF_FFF8;
              default: t = $urandom & 32'h0000_FFFF;
            endcase
            redirect_valid = 1;
            redirect_pc = t;
            exp_q.delete();
            gen_pc = t & ~32'h3;
          end
        end
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: gen_pc, w: mem_word(gen_pc)});
        gen_pc += 4;
      end
      #1;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", 32'(mem_q.size()), 0);
        mem_q.push_back('{a: imem_addr, due: c + ((c < 200) ? 1 : int'($urandom_range(3, 1)))});
      end
      if (c == 314) begin
        chk("full_no_req", {31'b0, imem_req_valid}, 0);
        chk("full_valid", {31'b0, instr_valid}, 1);
      end
    end
    done = 1;
    @(negedge clk);
    chk("progress", {31'b0, pops > 200}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares every consumed instruction against the scoreboard head.
  initial begin
    logic pv = 0, pr = 0, predir = 0, prst = 0;
    logic [31:0] paddr = 0, ptgt = 0;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_op", {25'b0, op}, 0);
      end else begin
        if (predir && prst)
          chk("redirect_addr", imem_addr, ptgt & ~32'h3);
        if (pv && !pr && !predir && prst && !redirect_valid) begin
          chk("req_hold_valid", {31'b0, imem_req_valid}, 1);
          chk("req_hold_addr", imem_addr, paddr);
        end
        if (imem_req_valid)
          chk("addr_align", {30'b0, imem_addr[1:0]}, 0);
        if (instr_valid && instr_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", instr_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.w);
            chk("op", {25'b0, op}, {25'b0, e.w[6:0]});
          end
        end
      end
      pv = imem_req_valid;
      pr = imem_req_ready;
      paddr = imem_addr;
      predir = redirect_valid;
      ptgt = redirect_pc;
      prst = rst_n;
    end
  end
endmodule
